// File: rtl/vtx_pkg.sv
// Shared definitions for the vertex transform block: default widths,
// the 4x4 coefficient matrix type, the control state encoding and the
// reset (identity) coefficient helper.
// Optional build macro used by the block: VTX_SATURATE_EN.
package vtx_pkg;

    // Default input/coefficient width, output width and fixed-point shift.
    localparam int VTX_DATA_W     = 14;
    localparam int VTX_OUT_W      = 11;
    localparam int VTX_FRAC_SHIFT = 4;

    // Diagonal value that represents 1.0 at the default fractional shift.
    localparam int VTX_ONE = 16;

    // Control states: waiting for a vertex, computing rows, presenting result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } vtx_state_t;

    // One signed coefficient and the row-major 4x4 matrix built from it.
    typedef logic signed [VTX_DATA_W-1:0] vtx_coef_t;
    typedef vtx_coef_t vtx_mat_t [4][4];

    // Reset value of matrix entry (r, c): diag(16,16,16,16), zero elsewhere.
    function automatic int vtx_reset_coef(input int r, input int c);
        return (r == c) ? VTX_ONE : 0;
    endfunction

endpackage

// File: rtl/vtx_row_mac.sv
// Single matrix-row dot product: c0*x + c1*y + c2*z + c3.
// Purely combinational; the top shares one instance across the three rows
// by steering the active row's coefficients onto c0..c3 each cycle.
// The accumulator is 2*DATA_W+2 bits so no partial sum can overflow.
module vtx_row_mac
    import vtx_pkg::*;
#(
    parameter int DATA_W = VTX_DATA_W,
    localparam int ACC_W = 2 * DATA_W + 2
) (
    input  logic signed [DATA_W-1:0] c0,
    input  logic signed [DATA_W-1:0] c1,
    input  logic signed [DATA_W-1:0] c2,
    input  logic signed [DATA_W-1:0] c3,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] y,
    input  logic signed [DATA_W-1:0] z,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [ACC_W-1:0] px;
    logic signed [ACC_W-1:0] py;
    logic signed [ACC_W-1:0] pz;

    // Sign-extend every operand to the accumulator width before multiplying
    // so products and the final sum are exact.
    always_comb begin
        px  = ACC_W'(c0) * ACC_W'(x);
        py  = ACC_W'(c1) * ACC_W'(y);
        pz  = ACC_W'(c2) * ACC_W'(z);
        acc = px + py + pz + ACC_W'(c3);
    end

endmodule

// File: rtl/vertex_transform.sv
// Affine vertex transform: out = (M * [x y z 1]^T) >>> FRAC_SHIFT, one
// output row per cycle through a shared row MAC (vtx_row_mac).
//
// Handshakes (both in_* and out_*): a transfer happens on a rising clock
// edge where valid and ready are both high; the producer keeps valid and
// its payload unchanged until that edge, and ready may depend on the
// consumer's own state combinationally.
//
// Coefficients are written into a shadow matrix at any time and copied to
// the active matrix only while no vertex is in flight, so every vertex is
// computed against one consistent matrix.
//
// Build option: define VTX_SATURATE_EN to clamp out-of-range results to the
// OUT_W signed limits; otherwise the low OUT_W bits are kept (wrap).
// ovf_sticky behaves the same in both builds.
module vertex_transform
    import vtx_pkg::*;
#(
    parameter int DATA_W     = VTX_DATA_W,
    parameter int OUT_W      = VTX_OUT_W,
    parameter int FRAC_SHIFT = VTX_FRAC_SHIFT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // vertex input stream
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_x,
    input  logic signed [DATA_W-1:0] in_y,
    input  logic signed [DATA_W-1:0] in_z,
    // transformed vertex output stream
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_x,
    output logic signed [OUT_W-1:0]  out_y,
    output logic signed [OUT_W-1:0]  out_z,
    // coefficient configuration
    input  logic                     cfg_we,
    input  logic [3:0]               cfg_addr,
    input  logic signed [DATA_W-1:0] cfg_data,
    input  logic                     cfg_commit,
    output logic                     cfg_pending,
    // overflow status
    input  logic                     ovf_clr,
    output logic                     ovf_sticky,
    // control state observation
    output logic [1:0]               dbg_state
);

    localparam int ACC_W = 2 * DATA_W + 2;
    localparam logic signed [ACC_W-1:0] RES_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] RES_MIN = -RES_MAX - ACC_W'(1);

    vtx_state_t state;
    logic [1:0] row;

    logic signed [DATA_W-1:0] vx;
    logic signed [DATA_W-1:0] vy;
    logic signed [DATA_W-1:0] vz;

    logic signed [DATA_W-1:0] shadow [4][4];
    logic signed [DATA_W-1:0] active [4][4];

    logic                     accept;
    logic                     apply_ok;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  shifted;
    logic                     row_ovf;
    logic signed [OUT_W-1:0]  row_res;

    // A new vertex can enter when idle, or when the current result leaves
    // on this same edge.
    assign in_ready  = (state == ST_IDLE) || ((state == ST_OUT) && out_ready);
    assign accept    = in_valid && in_ready;
    // A matrix copy is safe only when nothing is in flight or entering.
    assign apply_ok  = (state == ST_IDLE) && !accept;
    assign dbg_state = state;

    vtx_row_mac #(
        .DATA_W (DATA_W)
    ) u_row_mac (
        .c0  (active[row][0]),
        .c1  (active[row][1]),
        .c2  (active[row][2]),
        .c3  (active[row][3]),
        .x   (vx),
        .y   (vy),
        .z   (vz),
        .acc (acc)
    );

    // Scale the row result (floor shift), detect range violation and form
    // the OUT_W-bit value according to the build's overflow policy.
    always_comb begin
        shifted = acc >>> FRAC_SHIFT;
        row_ovf = (shifted > RES_MAX) || (shifted < RES_MIN);
`ifdef VTX_SATURATE_EN
        if (shifted > RES_MAX) begin
            row_res = RES_MAX[OUT_W-1:0];
        end else if (shifted < RES_MIN) begin
            row_res = RES_MIN[OUT_W-1:0];
        end else begin
            row_res = shifted[OUT_W-1:0];
        end
`else
        row_res = shifted[OUT_W-1:0];
`endif
    end

    // Latch the vertex on every accepted input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vx <= '0;
            vy <= '0;
            vz <= '0;
        end else if (accept) begin
            vx <= in_x;
            vy <= in_y;
            vz <= in_z;
        end
    end

    // Control FSM: accept, three row cycles, then hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            row       <= 2'd0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_CALC;
                        row   <= 2'd0;
                    end
                end
                ST_CALC: begin
                    // out_valid is low throughout CALC, so rows can be
                    // written straight into the output registers.
                    case (row)
                        2'd0:    out_x <= row_res;
                        2'd1:    out_y <= row_res;
                        default: out_z <= row_res;
                    endcase
                    if (row == 2'd2) begin
                        state     <= ST_OUT;
                        out_valid <= 1'b1;
                        row       <= 2'd0;
                    end else begin
                        row <= row + 2'd1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        row       <= 2'd0;
                        state     <= accept ? ST_CALC : ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Shadow writes, and shadow-to-active copy deferred until the datapath
    // is quiet; the copy reads the pre-edge shadow contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    shadow[r][c] <= DATA_W'(vtx_reset_coef(r, c));
                    active[r][c] <= DATA_W'(vtx_reset_coef(r, c));
                end
            end
            cfg_pending <= 1'b0;
        end else begin
            if (cfg_we) begin
                shadow[cfg_addr[3:2]][cfg_addr[1:0]] <= cfg_data;
            end
            if ((cfg_commit || cfg_pending) && apply_ok) begin
                active      <= shadow;
                cfg_pending <= 1'b0;
            end else if (cfg_commit) begin
                cfg_pending <= 1'b1;
            end
        end
    end

    // Sticky overflow flag; a new overflow outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if ((state == ST_CALC) && row_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vertex_transform.sv
// Self-checking bench for vertex_transform: reset values, a table of
// identity-matrix vectors, directed multi-cycle sequences (matrix load,
// offset/floor, stall with deferred commit, reset mid-CALC, overflow
// set/clear priority) and randomized traffic against a reference model.
// Honours VTX_SATURATE_EN to select the expected overflow policy.
module tb_vertex_transform;
    import vtx_pkg::*;

    localparam int DATA_W = 14;
    localparam int OUT_W  = 11;
    localparam int NRAND  = 60;
`ifdef VTX_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_x = '0, in_y = '0, in_z = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic signed [OUT_W-1:0]  out_x, out_y, out_z;
    logic                     cfg_we = 1'b0;
    logic [3:0]               cfg_addr = '0;
    logic signed [DATA_W-1:0] cfg_data = '0;
    logic                     cfg_commit = 1'b0;
    logic                     cfg_pending;
    logic                     ovf_clr = 1'b0;
    logic                     ovf_sticky;
    logic [1:0]               dbg_state;

    vertex_transform dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_z        (in_z),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_z       (out_z),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_commit  (cfg_commit),
        .cfg_pending (cfg_pending),
        .ovf_clr     (ovf_clr),
        .ovf_sticky  (ovf_sticky),
        .dbg_state   (dbg_state)
    );

    int checks = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    int m_shadow [16];
    int m_active [16];
    bit m_ovf;
    logic [3*OUT_W-1:0] exp_q[$];

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_shadow[i] = (i % 5 == 0) ? 16 : 0;
            m_active[i] = m_shadow[i];
        end
    endfunction

    // Exact dot product of one matrix row with (x, y, z, 1), floor-divided by 16.
    function automatic longint model_row(input int r, input int x, input int y, input int z);
        longint a;
        a = longint'(m_active[4*r]) * x + longint'(m_active[4*r+1]) * y
          + longint'(m_active[4*r+2]) * z + longint'(m_active[4*r+3]);
        return a >>> 4;
    endfunction

    function automatic bit model_ovf(input longint s);
        return (s > 1023) || (s < -1024);
    endfunction

    function automatic int model_out(input longint s);
        longint t;
        if (SAT) begin
            if (s > 1023) return 1023;
            if (s < -1024) return -1024;
            return int'(s);
        end
        t = s & 64'd2047;
        if (t >= 1024) t = t - 2048;
        return int'(t);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cfg_write(input int a, input int d);
        cfg_we   = 1'b1;
        cfg_addr = 4'(a);
        cfg_data = DATA_W'(d);
        @(negedge clk);
        cfg_we = 1'b0;
        m_shadow[a] = d;
    endtask

    task automatic load_matrix(input int v [16]);
        for (int i = 0; i < 16; i++) cfg_write(i, v[i]);
    endtask

    // Commit while idle with no vertex offered: takes effect on this edge.
    task automatic commit_idle();
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        m_active = m_shadow;
        check("commit_idle_pending", cfg_pending, 0);
    endtask

    task automatic pulse_ovf_clr();
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
    endtask

    // Offer one vertex, return its result and the accept-to-valid latency.
    task automatic run_vertex(input int x, input int y, input int z,
                              output int ox, output int oy, output int oz, output int lat);
        int n;
        out_ready = 1'b1;
        in_x = DATA_W'(x);
        in_y = DATA_W'(y);
        in_z = DATA_W'(z);
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        ox = int'(out_x);
        oy = int'(out_y);
        oz = int'(out_z);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int x, y, z;
        int ex, ey, ez;
        bit eovf;
    } vec_t;
    vec_t tbl [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ox, oy, oz, lat, n;
        int mat [16];
        int cx, cy, cz, sent, recv, cyc;
        bit acc_prev;
        longint s0, s1, s2;

        tbl[0] = '{x: 100,  y: -200,  z: 300, ex: 100,  ey: -200, ez: 300, eovf: 0};
        tbl[1] = '{x: -1,   y: 0,     z: 0,   ex: -1,   ey: 0,    ez: 0,   eovf: 0};
        tbl[2] = '{x: 2000, y: 0,     z: 0,   ex: SAT ? 1023 : -48,   ey: 0, ez: 0, eovf: 1};
        tbl[3] = '{x: 0,    y: -3000, z: 0,   ex: 0, ey: SAT ? -1024 : -952, ez: 0, eovf: 1};
        tbl[4] = '{x: 1023, y: -1024, z: -7,  ex: 1023, ey: -1024, ez: -7, eovf: 0};
        tbl[5] = '{x: 1024, y: 0,     z: 0,   ex: SAT ? 1023 : -1024, ey: 0, ez: 0, eovf: 1};

        model_reset();

        // Reset values while rst_n is held low.
        repeat (3) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_x", out_x, 0);
        check("reset_out_y", out_y, 0);
        check("reset_out_z", out_z, 0);
        check("reset_pending", cfg_pending, 0);
        check("reset_ovf", ovf_sticky, 0);
        check("reset_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", in_ready, 1);
        @(negedge clk);

        // Identity-matrix table, including range boundaries.
        for (int i = 0; i < 6; i++) begin
            run_vertex(tbl[i].x, tbl[i].y, tbl[i].z, ox, oy, oz, lat);
            check($sformatf("tbl%0d_latency", i), lat, 3);
            check($sformatf("tbl%0d_x", i), ox, tbl[i].ex);
            check($sformatf("tbl%0d_y", i), oy, tbl[i].ey);
            check($sformatf("tbl%0d_z", i), oz, tbl[i].ez);
            check($sformatf("tbl%0d_ovf", i), ovf_sticky, tbl[i].eovf);
            pulse_ovf_clr();
            check($sformatf("tbl%0d_ovf_cleared", i), ovf_sticky, 0);
        end

        // Overflow set on the same edge as a held clear: set must win.
        ovf_clr = 1'b1;
        run_vertex(0, 0, 2000, ox, oy, oz, lat);
        check("setclr_z", oz, SAT ? 1023 : -48);
        check("setclr_ovf_set_wins", ovf_sticky, 1);
        @(negedge clk);
        check("setclr_ovf_cleared", ovf_sticky, 0);
        ovf_clr = 1'b0;

        // Loaded matrix.
        mat = '{5, -3, -5, 0,  2, 7, -2, 0,  5, 0, 5, 0,  0, 0, 0, 8};
        load_matrix(mat);
        commit_idle();
        run_vertex(16, 16, 16, ox, oy, oz, lat);
        check("mat_x", ox, -3);
        check("mat_y", oy, 7);
        check("mat_z", oz, 10);

        // Offset column and floor rounding.
        mat = '{16, 0, 0, 32,  0, 16, 0, 0,  0, 0, 16, 0,  0, 0, 0, 16};
        load_matrix(mat);
        commit_idle();
        run_vertex(0, 0, 0, ox, oy, oz, lat);
        check("offset_x", ox, 2);
        run_vertex(-1, 0, 0, ox, oy, oz, lat);
        check("offset_floor_x", ox, 1);

        // Stall in OUT with a commit issued during CALC.
        mat = '{32, 0, 0, 0,  0, 32, 0, 0,  0, 0, 32, 0,  0, 0, 0, 16};
        load_matrix(mat);
        out_ready = 1'b0;
        in_x = 14'sd16; in_y = 14'sd32; in_z = 14'sd48;
        in_valid = 1'b1;
        #1;
        check("stall_in_ready_idle", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        check("stall_pending_set", cfg_pending, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_reach_out", n, 2);
        check("stall_x_old_matrix", out_x, 18);
        check("stall_y_old_matrix", out_y, 32);
        check("stall_z_old_matrix", out_z, 48);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_hold", (out_valid && !in_ready && cfg_pending &&
                                 out_x == 18 && out_y == 32 && out_z == 48), 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_pending_after_out", cfg_pending, 1);
        @(negedge clk);
        check("stall_pending_applied", cfg_pending, 0);
        m_active = m_shadow;
        run_vertex(16, 32, 48, ox, oy, oz, lat);
        check("new_matrix_x", ox, 32);
        check("new_matrix_y", oy, 64);
        check("new_matrix_z", oz, 96);

        // Reset asserted mid-CALC.
        in_x = 14'sd100; in_y = -14'sd200; in_z = 14'sd300;
        in_valid = 1'b1;
        #1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midreset_out_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("midreset_no_output", n, 0);
        check("midreset_out_x", out_x, 0);
        check("midreset_in_ready", in_ready, 1);
        run_vertex(100, -200, 300, ox, oy, oz, lat);
        check("midreset_identity_x", ox, 100);
        check("midreset_identity_y", oy, -200);
        check("midreset_identity_z", oz, 300);

        // Randomized traffic with random backpressure against the model.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 16; i++) begin
                if (i % 4 == 3) mat[i] = int'($urandom_range(0, 4000)) - 2000;
                else            mat[i] = int'($urandom_range(0, 20)) - 10;
            end
            load_matrix(mat);
            commit_idle();
            pulse_ovf_clr();
            m_ovf = 1'b0;
            sent = 0; recv = 0; cyc = 0; acc_prev = 1'b0;
            cx = 0; cy = 0; cz = 0;
            while (recv < NRAND && cyc < 4000) begin
                @(negedge clk);
                cyc++;
                out_ready = ($urandom_range(0, 3) != 0);
                if (in_valid && acc_prev) in_valid = 1'b0;
                if (!in_valid && sent < NRAND && $urandom_range(0, 2) != 0) begin
                    cx = int'($urandom_range(0, 2047)) - 1024;
                    cy = int'($urandom_range(0, 2047)) - 1024;
                    cz = int'($urandom_range(0, 2047)) - 1024;
                    in_x = DATA_W'(cx);
                    in_y = DATA_W'(cy);
                    in_z = DATA_W'(cz);
                    in_valid = 1'b1;
                end
                #1;
                acc_prev = in_valid && in_ready;
                if (acc_prev) begin
                    sent++;
                    s0 = model_row(0, cx, cy, cz);
                    s1 = model_row(1, cx, cy, cz);
                    s2 = model_row(2, cx, cy, cz);
                    m_ovf = m_ovf | model_ovf(s0) | model_ovf(s1) | model_ovf(s2);
                    exp_q.push_back({OUT_W'(model_out(s0)), OUT_W'(model_out(s1)),
                                     OUT_W'(model_out(s2))});
                end
                if (out_valid && out_ready) begin
                    recv++;
                    if (exp_q.size() == 0) check("rand_unexpected_output", 1, 0);
                    else check("rand_out", {out_x, out_y, out_z}, exp_q.pop_front());
                end
            end
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = 1'b1;
            check("rand_count", recv, NRAND);
            check("rand_ovf", ovf_sticky, m_ovf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
